// File: rtl/score_argmax_pkg.sv
// Shared defaults, FSM state type and score limits for score_argmax.
// Optional runner-up outputs are enabled by SCORE_ARGMAX_TOP2_EN.
package score_argmax_pkg;

  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_SCORE_W     = 32;
  localparam int unsigned DEF_IDX_W       = 4;

  // Most negative score at the default width.
  localparam logic [DEF_SCORE_W-1:0] SCORE_MIN = {1'b1, {(DEF_SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold
  } state_e;

endpackage

// File: rtl/score_argmax_cmp.sv
// Single-candidate compare/update step for the argmax scan; runner-up
// tracking is present only when SCORE_ARGMAX_TOP2_EN is defined.
module argmax_cmp #(
  parameter int unsigned SCORE_W = 32,
  parameter int unsigned IDX_W   = 4
) (
  input  logic [SCORE_W-1:0] i_cand,
  input  logic [IDX_W-1:0]   i_cand_idx,
  input  logic [SCORE_W-1:0] i_best,
  input  logic [IDX_W-1:0]   i_best_idx,
`ifdef SCORE_ARGMAX_TOP2_EN
  input  logic [SCORE_W-1:0] i_second,
  input  logic [IDX_W-1:0]   i_second_idx,
  output logic [SCORE_W-1:0] o_second,
  output logic [IDX_W-1:0]   o_second_idx,
`endif
  output logic [SCORE_W-1:0] o_best,
  output logic [IDX_W-1:0]   o_best_idx
);

  logic w_new_best;
  assign w_new_best = $signed(i_cand) > $signed(i_best);

  always_comb begin
    o_best     = i_best;
    o_best_idx = i_best_idx;
    if (w_new_best) begin
      o_best     = i_cand;
      o_best_idx = i_cand_idx;
    end
  end

`ifdef SCORE_ARGMAX_TOP2_EN
  // A new maximum demotes the old best; strict compares keep the lower index on ties.
  always_comb begin
    o_second     = i_second;
    o_second_idx = i_second_idx;
    if (w_new_best) begin
      o_second     = i_best;
      o_second_idx = i_best_idx;
    end else if ($signed(i_cand) > $signed(i_second)) begin
      o_second     = i_cand;
      o_second_idx = i_cand_idx;
    end
  end
`endif

endmodule

// File: rtl/score_argmax.sv
// Snapshots the accelerator's class scores on a ready rise and scans them one per cycle,
// presenting the argmax with a valid/ack handshake. SCORE_ARGMAX_TOP2_EN adds runner-up outputs.
module score_argmax
  import score_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned IDX_W       = DEF_IDX_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  input  logic                           ack,
  input  logic                           ovr_clr,
  output logic                           busy,
  output logic                           valid,
  output logic                           done,
  output logic [IDX_W-1:0]               digit,
  output logic [SCORE_W-1:0]             max_score,
  output logic                           overrun,
`ifdef SCORE_ARGMAX_TOP2_EN
  output logic [IDX_W-1:0]               second_digit,
  output logic [SCORE_W-1:0]             second_score,
  output logic [SCORE_W:0]               margin,
`endif
  output logic [15:0]                    frame_cnt
);

  localparam logic [SCORE_W-1:0] LP_SMIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]   LP_LAST = IDX_W'(NUM_CLASSES - 1);

  state_e             r_state;
  logic               r_ready_q;
  logic [SCORE_W-1:0] r_snap [NUM_CLASSES];
  logic [SCORE_W-1:0] r_best;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_i;
  logic               r_busy;
  logic               r_valid;
  logic               r_done;
  logic [IDX_W-1:0]   r_digit;
  logic [SCORE_W-1:0] r_max;
  logic               r_overrun;
  logic [15:0]        r_frame_cnt;

  logic               w_rise;
  logic               w_capture;
  logic               w_ovr_set;
  logic [SCORE_W-1:0] w_best_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;

  assign w_rise    = ready & ~r_ready_q;
  assign w_capture = w_rise & (r_state != StScan);
  // Overrun: a new set during a scan, or over a result nobody has acked yet.
  assign w_ovr_set = w_rise & ((r_state == StScan) |
                               ((r_state == StHold) & r_valid & ~ack));

`ifdef SCORE_ARGMAX_TOP2_EN
  logic [SCORE_W-1:0] r_second;
  logic [IDX_W-1:0]   r_second_idx;
  logic [IDX_W-1:0]   r_second_digit;
  logic [SCORE_W-1:0] r_second_score;
  logic [SCORE_W:0]   r_margin;
  logic [SCORE_W-1:0] w_second_nxt;
  logic [IDX_W-1:0]   w_second_idx_nxt;
  logic [SCORE_W:0]   w_margin;

  // Sign-extend both operands so the difference never overflows.
  assign w_margin = {w_best_nxt[SCORE_W-1], w_best_nxt}
                  - {w_second_nxt[SCORE_W-1], w_second_nxt};
`endif

  argmax_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_cmp (
    .i_cand       (r_snap[r_i]),
    .i_cand_idx   (r_i),
    .i_best       (r_best),
    .i_best_idx   (r_idx),
`ifdef SCORE_ARGMAX_TOP2_EN
    .i_second     (r_second),
    .i_second_idx (r_second_idx),
    .o_second     (w_second_nxt),
    .o_second_idx (w_second_idx_nxt),
`endif
    .o_best       (w_best_nxt),
    .o_best_idx   (w_idx_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ready_q   <= 1'b1;
      for (int k = 0; k < NUM_CLASSES; k++) r_snap[k] <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_i         <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_digit     <= '0;
      r_max       <= '0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
`ifdef SCORE_ARGMAX_TOP2_EN
      r_second       <= '0;
      r_second_idx   <= '0;
      r_second_digit <= '0;
      r_second_score <= '0;
      r_margin       <= '0;
`endif
    end else begin
      r_ready_q <= ready;
      r_done    <= 1'b0;

      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        StIdle, StHold: begin
          if (r_state == StHold && ack) begin
            r_valid <= 1'b0;
          end
          if (w_capture) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              r_snap[k] <= scores[k*SCORE_W +: SCORE_W];
            end
            r_best  <= scores[SCORE_W-1:0];
            r_idx   <= '0;
            r_i     <= IDX_W'(1);
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= StScan;
`ifdef SCORE_ARGMAX_TOP2_EN
            r_second     <= LP_SMIN;
            r_second_idx <= '0;
`endif
          end
        end

        StScan: begin
          r_best <= w_best_nxt;
          r_idx  <= w_idx_nxt;
`ifdef SCORE_ARGMAX_TOP2_EN
          r_second     <= w_second_nxt;
          r_second_idx <= w_second_idx_nxt;
`endif
          if (r_i == LP_LAST) begin
            r_state     <= StHold;
            r_busy      <= 1'b0;
            r_valid     <= 1'b1;
            r_done      <= 1'b1;
            r_digit     <= w_idx_nxt;
            r_max       <= w_best_nxt;
            r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef SCORE_ARGMAX_TOP2_EN
            r_second_digit <= w_second_idx_nxt;
            r_second_score <= w_second_nxt;
            r_margin       <= w_margin;
`endif
          end else begin
            r_i <= r_i + IDX_W'(1);
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign done      = r_done;
  assign digit     = r_digit;
  assign max_score = r_max;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;
`ifdef SCORE_ARGMAX_TOP2_EN
  assign second_digit = r_second_digit;
  assign second_score = r_second_score;
  assign margin       = r_margin;
`endif

endmodule

// File: tb/tb_score_argmax.sv
// Directed bench for score_argmax; runner-up checks compile in with SCORE_ARGMAX_TOP2_EN.
module tb_score_argmax;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic [319:0]  scores;
  logic          ack;
  logic          ovr_clr;
  logic          busy;
  logic          valid;
  logic          done;
  logic [3:0]    digit;
  logic [31:0]   max_score;
  logic          overrun;
  logic [15:0]   frame_cnt;
`ifdef SCORE_ARGMAX_TOP2_EN
  logic [3:0]    second_digit;
  logic [31:0]   second_score;
  logic [32:0]   margin;
`endif

  logic [31:0] sv [10];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 10; k++) scores[k*32 +: 32] = sv[k];
  end

  score_argmax dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .scores       (scores),
    .ack          (ack),
    .ovr_clr      (ovr_clr),
    .busy         (busy),
    .valid        (valid),
    .done         (done),
    .digit        (digit),
    .max_score    (max_score),
    .overrun      (overrun),
`ifdef SCORE_ARGMAX_TOP2_EN
    .second_digit (second_digit),
    .second_score (second_score),
    .margin       (margin),
`endif
    .frame_cnt    (frame_cnt)
  );

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_done;
    reset = 1'b1; ready = 1'b1; ack = 1'b0; ovr_clr = 1'b0;
    for (int k = 0; k < 10; k++) sv[k] = '0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_digit", digit, 0);
    chk("rst_max", max_score, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_frame", frame_cnt, 0);

    // ready held high across reset release must not start a capture
    reset = 1'b0;
    tick(3);
    chk("hold_ready_busy", busy, 0);
    chk("hold_ready_valid", valid, 0);
    ready = 1'b0;
    tick(1);

    // Set 1: tie between classes 2 and 4 resolves low
    sv = '{32'd5, 32'hFFFFFFFD, 32'd12, 32'd7, 32'd12, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    ready = 1'b1;
    tick(1);
    chk("t1_busy_start", busy, 1);
    chk("t1_valid_start", valid, 0);
    ready = 1'b0;
    for (int k = 0; k < 10; k++) sv[k] = 32'd99;
    tick(8);
    chk("t1_valid_early", valid, 0);
    chk("t1_busy_mid", busy, 1);
    tick(1);
    chk("t1_valid", valid, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_digit", digit, 2);
    chk("t1_max", max_score, 12);
    chk("t1_frame", frame_cnt, 1);
    tick(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_valid_held", valid, 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1_ack_valid", valid, 0);
    chk("t1_ack_digit", digit, 2);
    chk("t1_ack_ovr", overrun, 0);

    // Set 2: all equal negative values
    for (int k = 0; k < 10; k++) sv[k] = 32'hFFFFFF9C;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(9);
    chk("t2_valid", valid, 1);
    chk("t2_digit", digit, 0);
    chk("t2_max", max_score, 32'hFFFFFF9C);
    chk("t2_frame", frame_cnt, 2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;

    // Set 3: extreme signed values
    for (int k = 0; k < 10; k++) sv[k] = '0;
    sv[0] = 32'h80000000;
    sv[9] = 32'h7FFFFFFF;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(9);
    chk("t3_valid", valid, 1);
    chk("t3_digit", digit, 9);
    chk("t3_max", max_score, 32'h7FFFFFFF);
`ifdef SCORE_ARGMAX_TOP2_EN
    chk("t3_second_digit", second_digit, 1);
    chk("t3_second_score", second_score, 0);
    chk("t3_margin", margin, 33'h07FFFFFFF);
`endif
    ack = 1'b1;
    tick(1);
    ack = 1'b0;

    // Set 4: second ready rise mid-scan is ignored but flagged
    sv = '{32'd5, 32'hFFFFFFFD, 32'd12, 32'd7, 32'd12, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    sv = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd50, 32'd1, 32'd1, 32'd1, 32'd1};
    tick(3);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("t4_ovr_set", overrun, 1);
    chk("t4_busy", busy, 1);
    tick(4);
    chk("t4_valid_early", valid, 0);
    tick(1);
    chk("t4_valid", valid, 1);
    chk("t4_digit", digit, 2);
    chk("t4_frame", frame_cnt, 4);
    chk("t4_ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);

    // Set 5: ack and new rise in the same HOLD cycle
    ack = 1'b1;
    ready = 1'b1;
    tick(1);
    ack = 1'b0;
    ready = 1'b0;
    chk("t5_valid_drop", valid, 0);
    chk("t5_busy", busy, 1);
    chk("t5_no_ovr", overrun, 0);
    tick(9);
    chk("t5_valid", valid, 1);
    chk("t5_digit", digit, 5);
    chk("t5_max", max_score, 50);
    chk("t5_frame", frame_cnt, 5);
    chk("t5_ovr_still0", overrun, 0);

    // Unacked result overwritten, then aborted by reset mid-scan
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("t6_ovr_set", overrun, 1);
    chk("t6_busy", busy, 1);
    chk("t6_valid_drop", valid, 0);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovr", overrun, 0);
    chk("t6_rst_digit", digit, 0);
    chk("t6_rst_max", max_score, 0);
    chk("t6_rst_frame", frame_cnt, 0);
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      seen_done = seen_done | done | valid;
    end
    chk("t6_no_done", seen_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
